sbox_share_arb: RTL and testbench
=================================

# sbox_share_arb

Arbiter and sequencer that shares one pipelined SubBytes engine between two requesters: the round datapath (full 128-bit state) and the key-expansion unit (32-bit SubWord). It grants at most one request per cycle into the engine and tracks each in-flight operation with a tag pipeline matched to the engine latency. It routes each result back to its owner through a per-port response register with valid/ready handshake. It sits between the round controller, the key scheduler and the SubBytes instance.

## Interface
- DATA_W, 128: engine data width; must be a multiple of 32.
- LAT, 1: engine latency in cycles from `sb_valid_in` to `sb_valid_out`; legal range 1..4.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- rd_valid  in  1  round-datapath request valid.
- rd_ready  out  1  round-datapath request accepted this cycle.
- rd_data  in  DATA_W  round state to substitute.
- ks_valid  in  1  key-schedule request valid.
- ks_ready  out  1  key-schedule request accepted this cycle.
- ks_data  in  32  word to substitute.
- rd_resp_valid  out  1  round result held.
- rd_resp_ready  in  1  round consumer takes result.
- rd_resp_data  out  DATA_W  substituted state.
- ks_resp_valid  out  1  key result held.
- ks_resp_ready  in  1  key consumer takes result.
- ks_resp_data  out  32  substituted word.
- sb_valid_in  out  1  engine input valid.
- sb_data_in  out  DATA_W  engine input data.
- sb_valid_out  in  1  engine output valid.
- sb_data_out  in  DATA_W  engine output data.
- err  out  1  sticky protocol error.

## Operation
- Each port may have at most one operation outstanding, counted from grant until its response is consumed. Port p is eligible when p_valid=1, p is not in flight, and the p response register is empty.
- Arbitration, one grant per cycle:
  - If only one port is eligible, that port is granted.
  - If both are eligible, the round-robin pointer decides. The pointer resets to KS. After any grant it points to the port that was not granted.
- Grant drives the engine in the same cycle:
  - `p_ready`=1.
  - `sb_valid_in`=1.
  - `sb_data_in` = rd_data, or {zeros, ks_data} with ks_data in bits [31:0].
  - With no grant, `sb_valid_in`=0 and `sb_data_in` holds its last value.
- Tag pipeline:
  - LAT stages of {valid, id}. Stage 0 loads {grant, granted id}. Stages shift every cycle.
  - When `sb_valid_out`=1, the last stage's id selects the destination response register. RD stores all DATA_W bits; KS stores bits [31:0].
- Response register:
  - Sets on capture.
  - Clears on `p_resp_valid & p_resp_ready`.
  - The port's in-flight flag clears on the same handshake.
- `err` sets and stays set until reset on either of:
  - `sb_valid_out` not equal to the last-stage tag valid.
  - Capture into an occupied response register. In this case the old data is kept and the new data is dropped.

## Timing
- Reset values:
  - rd_ready=0, ks_ready=0.
  - rd_resp_valid=0, ks_resp_valid=0.
  - rd_resp_data=0, ks_resp_data=0.
  - sb_valid_in=0, sb_data_in=0, err=0.
  - Tag pipeline cleared, in-flight flags cleared, pointer=KS.
- `p_ready` and `sb_valid_in` are combinational from the valids and registered state. They never depend on `p_resp_ready`.
- Latency: request accepted at cycle N gives `p_resp_valid`=1 at cycle N+LAT+1.
- A port's response handshake at cycle M makes that port eligible again at cycle M+1, never at cycle M.
- Simultaneous capture and consume on the same port cannot occur, because of the one-outstanding rule.
- Both ports can have an operation in flight at the same time. Back-to-back grants to alternating ports are legal.
- Reset mid-operation drops every in-flight tag and every held response. The engine is reset by the same signal.

## Configuration
- `SBOX_ARB_KS_PRIO_EN`
  - Defined: fixed priority. KS wins whenever both ports are eligible, and the pointer is unused.
  - Undefined: round-robin as described under Operation.

## Test plan
- Single RD request, rd_data=0x00112233445566778899aabbccddeeff, LAT=1 -> rd_ready=1 in the request cycle. Two cycles later rd_resp_data=0x638293c31bfc33f5c4eeacea4bc12816 and rd_resp_valid=1.
- KS request ks_data=0x09cf4f3c -> ks_resp_data=0x018a84eb after LAT+1 cycles. rd_resp_valid stays 0.
- Both valids high continuously with consumers always ready -> first grant KS, then alternating RD, KS, RD. With `SBOX_ARB_KS_PRIO_EN` defined, KS is granted every time it is eligible.
- rd_resp_ready held 0 for 10 cycles while rd_valid stays 1 -> exactly one RD grant and no further rd_ready. KS traffic continues unaffected.
- Reset asserted while both ports are in flight -> all outputs return to reset values at once. No response appears after reset release.
- Inject a spurious sb_valid_out=1 with an empty tag pipeline -> err=1 and it stays 1. Neither response register changes.

Source files
------------

// File: rtl/sbox_share_arb.sv
// Shares one pipelined SubBytes engine between the round datapath (RD) and key expansion (KS).
// Build option SBOX_ARB_KS_PRIO_EN: KS wins every tie (fixed priority) instead of round-robin.
module sbox_share_arb #(
    parameter int DATA_W = 128,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              ks_valid,
    output logic              ks_ready,
    input  logic [31:0]       ks_data,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic              ks_resp_valid,
    input  logic              ks_resp_ready,
    output logic [31:0]       ks_resp_data,
    output logic              sb_valid_in,
    output logic [DATA_W-1:0] sb_data_in,
    input  logic              sb_valid_out,
    input  logic [DATA_W-1:0] sb_data_out,
    output logic              err
);
    localparam logic ID_RD = 1'b0;
    localparam logic ID_KS = 1'b1;

    logic              run_q;
    logic              rd_inflight_q, rd_inflight_d;
    logic              ks_inflight_q, ks_inflight_d;
    logic              rd_resp_valid_q, rd_resp_valid_d;
    logic [DATA_W-1:0] rd_resp_data_q, rd_resp_data_d;
    logic              ks_resp_valid_q, ks_resp_valid_d;
    logic [31:0]       ks_resp_data_q, ks_resp_data_d;
    logic [DATA_W-1:0] sb_data_q;
    logic              err_q, err_d;
    logic [LAT-1:0]    tag_v_q;
    logic [LAT-1:0]    tag_id_q;
`ifndef SBOX_ARB_KS_PRIO_EN
    logic              ptr_ks_q, ptr_ks_d;
`endif

    logic              rd_elig_s, ks_elig_s;
    logic              gnt_rd_s, gnt_ks_s;
    logic [DATA_W-1:0] ks_ext_s;
    logic              last_v_s, last_id_s;
    logic              cap_rd_s, cap_ks_s;
    logic              rd_hs_s, ks_hs_s;

    // Eligibility and one-grant-per-cycle arbitration
    always_comb begin
        rd_elig_s = run_q & rd_valid & ~rd_inflight_q & ~rd_resp_valid_q;
        ks_elig_s = run_q & ks_valid & ~ks_inflight_q & ~ks_resp_valid_q;
        gnt_rd_s  = 1'b0;
        gnt_ks_s  = 1'b0;
        case ({rd_elig_s, ks_elig_s})
            2'b10: gnt_rd_s = 1'b1;
            2'b01: gnt_ks_s = 1'b1;
            2'b11: begin
`ifdef SBOX_ARB_KS_PRIO_EN
                gnt_ks_s = 1'b1;
`else
                if (ptr_ks_q) begin
                    gnt_ks_s = 1'b1;
                end else begin
                    gnt_rd_s = 1'b1;
                end
`endif
            end
            default: begin
                gnt_rd_s = 1'b0;
                gnt_ks_s = 1'b0;
            end
        endcase
    end

    // Engine input mux; holds the last driven value when idle
    always_comb begin
        ks_ext_s       = '0;
        ks_ext_s[31:0] = ks_data;
        if (gnt_rd_s) begin
            sb_data_in = rd_data;
        end else if (gnt_ks_s) begin
            sb_data_in = ks_ext_s;
        end else begin
            sb_data_in = sb_data_q;
        end
    end

    assign rd_ready    = gnt_rd_s;
    assign ks_ready    = gnt_ks_s;
    assign sb_valid_in = gnt_rd_s | gnt_ks_s;

    // Result routing, in-flight bookkeeping and sticky error
    always_comb begin
        last_v_s  = tag_v_q[LAT-1];
        last_id_s = tag_id_q[LAT-1];
        cap_rd_s  = sb_valid_out & last_v_s & (last_id_s == ID_RD);
        cap_ks_s  = sb_valid_out & last_v_s & (last_id_s == ID_KS);
        rd_hs_s   = rd_resp_valid_q & rd_resp_ready;
        ks_hs_s   = ks_resp_valid_q & ks_resp_ready;

        rd_resp_valid_d = rd_resp_valid_q;
        rd_resp_data_d  = rd_resp_data_q;
        if (cap_rd_s && !rd_resp_valid_q) begin
            rd_resp_valid_d = 1'b1;
            rd_resp_data_d  = sb_data_out;
        end else if (rd_hs_s) begin
            rd_resp_valid_d = 1'b0;
        end else begin
            rd_resp_valid_d = rd_resp_valid_q;
        end

        ks_resp_valid_d = ks_resp_valid_q;
        ks_resp_data_d  = ks_resp_data_q;
        if (cap_ks_s && !ks_resp_valid_q) begin
            ks_resp_valid_d = 1'b1;
            ks_resp_data_d  = sb_data_out[31:0];
        end else if (ks_hs_s) begin
            ks_resp_valid_d = 1'b0;
        end else begin
            ks_resp_valid_d = ks_resp_valid_q;
        end

        rd_inflight_d = rd_inflight_q;
        if (gnt_rd_s) begin
            rd_inflight_d = 1'b1;
        end else if (rd_hs_s) begin
            rd_inflight_d = 1'b0;
        end else begin
            rd_inflight_d = rd_inflight_q;
        end

        ks_inflight_d = ks_inflight_q;
        if (gnt_ks_s) begin
            ks_inflight_d = 1'b1;
        end else if (ks_hs_s) begin
            ks_inflight_d = 1'b0;
        end else begin
            ks_inflight_d = ks_inflight_q;
        end

        // A capture into a full register keeps the old data and flags the overrun
        err_d = err_q | (sb_valid_out != last_v_s)
                      | (cap_rd_s & rd_resp_valid_q)
                      | (cap_ks_s & ks_resp_valid_q);

`ifndef SBOX_ARB_KS_PRIO_EN
        ptr_ks_d = ptr_ks_q;
        if (gnt_rd_s) begin
            ptr_ks_d = 1'b1;
        end else if (gnt_ks_s) begin
            ptr_ks_d = 1'b0;
        end else begin
            ptr_ks_d = ptr_ks_q;
        end
`endif
    end

    // State registers and tag pipeline
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q           <= 1'b0;
            rd_inflight_q   <= 1'b0;
            ks_inflight_q   <= 1'b0;
            rd_resp_valid_q <= 1'b0;
            rd_resp_data_q  <= '0;
            ks_resp_valid_q <= 1'b0;
            ks_resp_data_q  <= 32'h0;
            sb_data_q       <= '0;
            err_q           <= 1'b0;
            tag_v_q         <= '0;
            tag_id_q        <= '0;
        end else begin
            run_q           <= 1'b1;
            rd_inflight_q   <= rd_inflight_d;
            ks_inflight_q   <= ks_inflight_d;
            rd_resp_valid_q <= rd_resp_valid_d;
            rd_resp_data_q  <= rd_resp_data_d;
            ks_resp_valid_q <= ks_resp_valid_d;
            ks_resp_data_q  <= ks_resp_data_d;
            sb_data_q       <= sb_data_in;
            err_q           <= err_d;
            tag_v_q[0]      <= gnt_rd_s | gnt_ks_s;
            tag_id_q[0]     <= gnt_ks_s;
            for (int i = 1; i < LAT; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

`ifndef SBOX_ARB_KS_PRIO_EN
    // Round-robin pointer, resets to KS
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_ks_q <= 1'b1;
        end else begin
            ptr_ks_q <= ptr_ks_d;
        end
    end
`endif

    assign rd_resp_valid = rd_resp_valid_q;
    assign rd_resp_data  = rd_resp_data_q;
    assign ks_resp_valid = ks_resp_valid_q;
    assign ks_resp_data  = ks_resp_data_q;
    assign err           = err_q;
endmodule

// File: tb/tb_sbox_share_arb.sv
// Directed bench for sbox_share_arb with a behavioural 1-cycle AES SubBytes engine.
module tb_sbox_share_arb;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rd_valid = 1'b0, ks_valid = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    logic [31:0]       ks_data = 32'h0;
    logic              rd_resp_ready = 1'b0, ks_resp_ready = 1'b0;
    logic              rd_ready, ks_ready, rd_resp_valid, ks_resp_valid;
    logic [DATA_W-1:0] rd_resp_data;
    logic [31:0]       ks_resp_data;
    logic              sb_valid_in, sb_valid_out, err;
    logic [DATA_W-1:0] sb_data_in, sb_data_out;
    logic              eng_v;
    logic [DATA_W-1:0] eng_d;
    logic              inject = 1'b0;

    int n_err = 0;
    int n_checks = 0;

    logic [7:0] sbox_tab [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [DATA_W-1:0] sub_bytes(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int b = 0; b < DATA_W / 8; b++) r[b*8 +: 8] = sbox_tab[x[b*8 +: 8]];
        return r;
    endfunction

    sbox_share_arb #(.DATA_W(DATA_W), .LAT(1)) dut (
        .clk(clk), .reset(reset),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
        .ks_resp_valid(ks_resp_valid), .ks_resp_ready(ks_resp_ready), .ks_resp_data(ks_resp_data),
        .sb_valid_in(sb_valid_in), .sb_data_in(sb_data_in),
        .sb_valid_out(sb_valid_out), .sb_data_out(sb_data_out),
        .err(err)
    );

    always #5 clk = ~clk;

    // One-cycle engine, reset together with the arbiter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_v <= 1'b0;
            eng_d <= '0;
        end else begin
            eng_v <= sb_valid_in;
            eng_d <= sub_bytes(sb_data_in);
        end
    end
    assign sb_valid_out = eng_v | inject;
    assign sb_data_out  = eng_d;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rd_valid = 1'b0; ks_valid = 1'b0;
        rd_resp_ready = 1'b0; ks_resp_ready = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rd_ready"}, rd_ready, 1'b0);
        chk({tag, "_ks_ready"}, ks_ready, 1'b0);
        chk({tag, "_rd_rv"}, rd_resp_valid, 1'b0);
        chk({tag, "_ks_rv"}, ks_resp_valid, 1'b0);
        chk({tag, "_rd_rdata"}, rd_resp_data, 128'h0);
        chk({tag, "_ks_rdata"}, ks_resp_data, 32'h0);
        chk({tag, "_sb_v"}, sb_valid_in, 1'b0);
        chk({tag, "_sb_d"}, sb_data_in, 128'h0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    typedef struct {
        logic         rd_v;
        logic [127:0] rd_d;
        logic         ks_v;
        logic [31:0]  ks_d;
        logic         e_rd;
        logic         e_ks;
        logic [127:0] e_rd_resp;
        logic [31:0]  e_ks_resp;
    } vec_t;

    vec_t vecs [6];
    int   gseq [8];
    int   ng, dbl, rd_cnt, ks_cnt;

    initial begin
        vecs[0] = '{1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0, 32'h0,
                    1'b1, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816, 32'h0};
        vecs[1] = '{1'b0, 128'h0, 1'b1, 32'h09cf4f3c,
                    1'b0, 1'b1, 128'h0, 32'h018a84eb};
`ifdef SBOX_ARB_KS_PRIO_EN
        vecs[2] = '{1'b1, 128'h0, 1'b1, 32'h0,
                    1'b0, 1'b1, 128'h0, 32'h63636363};
`else
        vecs[2] = '{1'b1, 128'h0, 1'b1, 32'h0,
                    1'b1, 1'b0, 128'h63636363636363636363636363636363, 32'h0};
`endif
        vecs[3] = '{1'b1, {128{1'b1}}, 1'b1, 32'h01020304,
                    1'b0, 1'b1, 128'h0, 32'h7c777bf2};
        vecs[4] = '{1'b1, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0, 32'h0,
                    1'b1, 1'b0, 128'h7672d8ebb3bef9bc1790068d2eb5f88c, 32'h0};
        vecs[5] = '{1'b0, 128'h0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 32'h0};

        do_reset();
        @(negedge clk);
        chk_reset_state("rst");
        step();

        // Table: grant, latency and routing per request
        for (int i = 0; i < 6; i++) begin
            rd_valid = vecs[i].rd_v; rd_data = vecs[i].rd_d;
            ks_valid = vecs[i].ks_v; ks_data = vecs[i].ks_d;
            @(negedge clk);
            chk($sformatf("v%0d_rd_ready", i), rd_ready, vecs[i].e_rd);
            chk($sformatf("v%0d_ks_ready", i), ks_ready, vecs[i].e_ks);
            chk($sformatf("v%0d_sb_v", i), sb_valid_in, vecs[i].e_rd | vecs[i].e_ks);
            if (vecs[i].e_rd) chk($sformatf("v%0d_sb_d", i), sb_data_in, vecs[i].rd_d);
            else if (vecs[i].e_ks) chk($sformatf("v%0d_sb_d", i), sb_data_in, {96'h0, vecs[i].ks_d});
            step();
            rd_valid = 1'b0; ks_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_early", i), {rd_resp_valid, ks_resp_valid}, 2'b00);
            step();
            @(negedge clk);
            chk($sformatf("v%0d_rd_rv", i), rd_resp_valid, vecs[i].e_rd);
            chk($sformatf("v%0d_ks_rv", i), ks_resp_valid, vecs[i].e_ks);
            if (vecs[i].e_rd) chk($sformatf("v%0d_rd_data", i), rd_resp_data, vecs[i].e_rd_resp);
            if (vecs[i].e_ks) chk($sformatf("v%0d_ks_data", i), ks_resp_data, vecs[i].e_ks_resp);
            step();
            rd_resp_ready = 1'b1; ks_resp_ready = 1'b1;
            step();
            rd_resp_ready = 1'b0; ks_resp_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_cleared", i), {rd_resp_valid, ks_resp_valid}, 2'b00);
            step();
        end
        chk("table_err", err, 1'b0);

        // Both ports saturated, consumers always ready
        do_reset();
        rd_valid = 1'b1; rd_data = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        ks_valid = 1'b1; ks_data = 32'h09cf4f3c;
        rd_resp_ready = 1'b1; ks_resp_ready = 1'b1;
        ng = 0; dbl = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rd_ready && ks_ready) dbl++;
            if (ks_ready && ng < 8) begin gseq[ng] = 1; ng++; end
            else if (rd_ready && ng < 8) begin gseq[ng] = 2; ng++; end
            if (rd_resp_valid) chk("sat_rd_data", rd_resp_data, 128'h7672d8ebb3bef9bc1790068d2eb5f88c);
            if (ks_resp_valid) chk("sat_ks_data", ks_resp_data, 32'h018a84eb);
            step();
        end
        rd_valid = 1'b0; ks_valid = 1'b0;
        chk("sat_double_grant", dbl, 0);
        chk("sat_grant_count", ng, 8);
        chk("sat_g0_ks", gseq[0], 1);
        chk("sat_g1_rd", gseq[1], 2);
        chk("sat_g2_ks", gseq[2], 1);
        chk("sat_g3_rd", gseq[3], 2);

        // RD consumer stalls; KS keeps flowing
        do_reset();
        rd_valid = 1'b1; rd_data = 128'h00112233445566778899aabbccddeeff;
        ks_valid = 1'b1; ks_data = 32'h09cf4f3c;
        ks_resp_ready = 1'b1;
        rd_cnt = 0; ks_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rd_ready) rd_cnt++;
            if (ks_ready) ks_cnt++;
            step();
        end
        chk("stall_rd_grants", rd_cnt, 1);
        chk("stall_ks_grants", ks_cnt, 4);
        chk("stall_rd_rv", rd_resp_valid, 1'b1);
        chk("stall_rd_data", rd_resp_data, 128'h638293c31bfc33f5c4eeacea4bc12816);
        ks_valid = 1'b0;
        rd_resp_ready = 1'b1;
        @(negedge clk);
        chk("hs_cycle_no_regrant", rd_ready, 1'b0);
        step();
        rd_resp_ready = 1'b0;
        @(negedge clk);
        chk("after_hs_regrant", rd_ready, 1'b1);
        step();
        rd_valid = 1'b0;

        // Reset while both ports are in flight
        do_reset();
        rd_valid = 1'b1; ks_valid = 1'b1;
        step();
        step();
        rd_valid = 1'b0; ks_valid = 1'b0;
        @(negedge clk);
        chk("mid_ks_rv", ks_resp_valid, 1'b1);
        step();
        reset = 1'b0;
        #1;
        chk_reset_state("mid_rst");
        step(); step();
        reset = 1'b1;
        ng = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rd_resp_valid || ks_resp_valid || err) ng++;
            step();
        end
        chk("post_rst_quiet", ng, 0);

        // Spurious engine valid with an empty tag pipeline
        chk("pre_inject_err", err, 1'b0);
        inject = 1'b1;
        step();
        inject = 1'b0;
        @(negedge clk);
        chk("inject_err", err, 1'b1);
        chk("inject_rv", {rd_resp_valid, ks_resp_valid}, 2'b00);
        chk("inject_rd_data", rd_resp_data, 128'h0);
        chk("inject_ks_data", ks_resp_data, 32'h0);
        repeat (5) step();
        @(negedge clk);
        chk("err_sticky", err, 1'b1);
        do_reset();
        @(negedge clk);
        chk("err_cleared_by_reset", err, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
